// File: rtl/jk_mod_counter_pkg.sv
// -----------------------------------------------------------------------------
// jk_mod_counter_pkg
//   Shared definitions for the JK-flip-flop based modulo-N counter.
//   - JK_DEFAULT_WIDTH / JK_DEFAULT_MODULUS : default counter geometry
//   - jk_op_e                               : 2-bit {J,K} excitation encoding
//                                             (JK_HOLD / JK_RST / JK_SET / JK_TGL)
//   - jk_excite()                           : excitation for one stage, derived
//                                             from its current and next bit
//   Optional feature macro used by the files importing this package:
//   JK_LOAD_EN (synchronous parallel load).
// -----------------------------------------------------------------------------
package jk_mod_counter_pkg;

   localparam int JK_DEFAULT_WIDTH   = 4;
   localparam int JK_DEFAULT_MODULUS = 10;

   // Encoding is the literal {J,K} pair, so a stage can decode {j,k} directly.
   typedef enum logic [1:0] {
      JK_HOLD = 2'b00,
      JK_RST  = 2'b01,
      JK_SET  = 2'b10,
      JK_TGL  = 2'b11
   } jk_op_e;

   // Drive J only on a 0->1 transition and K only on a 1->0 transition.
   // A stage that does not change gets HOLD, so J=K=1 is never produced.
   function automatic jk_op_e jk_excite(input logic nxt_bit, input logic q_bit);
      jk_op_e op;
      op = jk_op_e'({nxt_bit & ~q_bit, ~nxt_bit & q_bit});
      return op;
   endfunction

endpackage : jk_mod_counter_pkg

// File: rtl/jk_mod_counter_if.sv
// -----------------------------------------------------------------------------
// jk_mod_counter_if
//   Control/status bundle of one jk_mod_counter.
//   Signals:
//     en     count enable (cascade input)
//     up_dn  1 = count up, 0 = count down
//     load   parallel load strobe        (only with JK_LOAD_EN)
//     din    parallel load value [WIDTH] (only with JK_LOAD_EN)
//     q      current count [WIDTH]
//     tc     terminal count (combinational)
//   Modports:
//     master : the controlling side (drives en/up_dn/load/din)
//     slave  : the counter itself   (drives q/tc)
//   Macro: JK_LOAD_EN adds load/din.
// -----------------------------------------------------------------------------
interface jk_mod_counter_if
   import jk_mod_counter_pkg::*;
#(
   parameter int WIDTH = JK_DEFAULT_WIDTH
) ();

   logic             en;
   logic             up_dn;
`ifdef JK_LOAD_EN
   logic             load;
   logic [WIDTH-1:0] din;
`endif
   logic [WIDTH-1:0] q;
   logic             tc;

   modport master (
`ifdef JK_LOAD_EN
      output load,
      output din,
`endif
      output en,
      output up_dn,
      input  q,
      input  tc
   );

   modport slave (
`ifdef JK_LOAD_EN
      input  load,
      input  din,
`endif
      input  en,
      input  up_dn,
      output q,
      output tc
   );

endinterface : jk_mod_counter_if

// File: rtl/jk_stage.sv
// -----------------------------------------------------------------------------
// jk_stage
//   One negative-edge JK flip-flop with asynchronous active-low clear,
//   no preset.
//   Ports:
//     clk_n  in  clock, state changes on the falling edge
//     clr_n  in  asynchronous active-low clear, forces q to 0
//     j, k   in  JK excitation (00 hold, 01 reset, 10 set, 11 toggle)
//     q      out stored bit
// -----------------------------------------------------------------------------
module jk_stage
   import jk_mod_counter_pkg::*;
(
   input  logic clk_n,
   input  logic clr_n,
   input  logic j,
   input  logic k,
   output logic q
);

   logic q_q;
   logic q_d;

   always_comb begin
      q_d = q_q;
      case (jk_op_e'({j, k}))
         JK_HOLD: q_d = q_q;
         JK_RST:  q_d = 1'b0;
         JK_SET:  q_d = 1'b1;
         JK_TGL:  q_d = ~q_q;
         default: q_d = q_q;
      endcase
   end

   always_ff @(negedge clk_n or negedge clr_n) begin
      if (!clr_n) begin
         q_q <= 1'b0;
      end else begin
         q_q <= q_d;
      end
   end

   assign q = q_q;

endmodule : jk_stage

// File: rtl/jk_mod_counter.sv
// -----------------------------------------------------------------------------
// jk_mod_counter
//   Synchronous modulo-MODULUS up/down counter built from WIDTH negative-edge
//   JK stages. This level only computes the next count, turns it into per-stage
//   J/K excitation and decodes terminal count; the state lives in jk_stage.
//   Parameters:
//     WIDTH    number of stages / count bits (1..16)
//     MODULUS  count range 0..MODULUS-1, 2 <= MODULUS <= 2**WIDTH
//   Ports:
//     clk_n  in  clock, falling-edge active
//     clr_n  in  asynchronous active-low clear, q -> 0 immediately
//     bus    slave side of jk_mod_counter_if (en, up_dn, [load, din], q, tc)
//   Macro: JK_LOAD_EN enables the synchronous parallel load (load > en > hold).
//   The interface instance must be built with the same WIDTH.
// -----------------------------------------------------------------------------
module jk_mod_counter
   import jk_mod_counter_pkg::*;
#(
   parameter int WIDTH   = JK_DEFAULT_WIDTH,
   parameter int MODULUS = JK_DEFAULT_MODULUS
) (
   input  logic            clk_n,
   input  logic            clr_n,
   jk_mod_counter_if.slave bus
);

   localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MODULUS - 1);
   localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

   logic [WIDTH-1:0] q_w;     // current count, straight from the stage bank
   logic [WIDTH-1:0] nxt_d;   // count-path next state (load handled per stage)

   // Next state of the counting path. Anything at or above MAX_Q wraps to 0
   // going up, so states above MODULUS-1 (only reachable by a load) recover
   // in one edge; going down they jump to MAX_Q.
   always_comb begin
      nxt_d = q_w;
      if (bus.en) begin
         if (bus.up_dn) begin
            nxt_d = (q_w >= MAX_Q) ? '0 : q_w + ONE;
         end else begin
            nxt_d = ((q_w == '0) || (q_w > MAX_Q)) ? MAX_Q : q_w - ONE;
         end
      end
   end

   // Per-stage excitation and the flip-flop bank.
   for (genvar gi = 0; gi < WIDTH; gi++) begin : g_stage
      logic [1:0] cnt_jk_w;
      logic [1:0] jk_w;

      assign cnt_jk_w = jk_excite(nxt_d[gi], q_w[gi]);

`ifdef JK_LOAD_EN
      // A load forces the stage directly: J=din, K=~din, regardless of q.
      assign jk_w = bus.load ? (bus.din[gi] ? JK_SET : JK_RST) : cnt_jk_w;
`else
      assign jk_w = cnt_jk_w;
`endif

      jk_stage u_stage (
         .clk_n (clk_n),
         .clr_n (clr_n),
         .j     (jk_w[1]),
         .k     (jk_w[0]),
         .q     (q_w[gi])
      );
   end

   assign bus.q = q_w;

   // Terminal count is purely combinational so a cascaded counter sees it as
   // its enable on the same falling edge; it follows clr_n through q.
   assign bus.tc = bus.en & (bus.up_dn ? (q_w == MAX_Q) : (q_w == '0));

endmodule : jk_mod_counter
